// File: rtl/switch_debounce.sv
// switch_debounce: per-bit synchroniser and stability-counter debouncer
// with registered rise/fall pulses and a sticky, CPU-clearable change flag.
module switch_debounce #(
    parameter int WIDTH         = 4,
    parameter int STABLE_CYCLES = 500000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] sw_i,
    input  logic             clr_i,
    output logic [WIDTH-1:0] sw_o,
    output logic [WIDTH-1:0] rise_o,
    output logic [WIDTH-1:0] fall_o,
    output logic [WIDTH-1:0] event_o
);

    localparam int CW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(STABLE_CYCLES - 1);

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    logic [CW-1:0]    cnt [WIDTH];
    logic [WIDTH-1:0] flip;

    // Two-flop synchroniser; only sync2 is trusted downstream.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= sw_i;
            sync2 <= sync1;
        end
    end

    // A bit flips once it has disagreed with the level for the full window.
    always_comb begin
        flip = '0;
        for (int i = 0; i < WIDTH; i++) begin
            flip[i] = (sync2[i] != sw_o[i]) && (cnt[i] == LAST);
        end
    end

    // Stability counters: any agreement restarts the window; never wraps.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (sync2[i] == sw_o[i] || cnt[i] == LAST) begin
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CW'(1);
                end
            end
        end
    end

    // Debounced level, edge pulses and sticky flags; a set beats a clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            sw_o    <= '0;
            rise_o  <= '0;
            fall_o  <= '0;
            event_o <= '0;
        end else begin
            sw_o    <= sw_o ^ flip;
            rise_o  <= flip & sync2;
            fall_o  <= flip & ~sync2;
            event_o <= (clr_i ? '0 : event_o) | flip;
        end
    end

endmodule

// File: tb/tb_switch_debounce.sv
// tb_switch_debounce: directed checks of the debouncer with a
// short stability window so each scenario resolves in a few cycles.
module tb_switch_debounce;

    localparam int W  = 4;
    localparam int SC = 4;

    logic         clk;
    logic         rst;
    logic [W-1:0] sw_i;
    logic         clr_i;
    logic [W-1:0] sw_o;
    logic [W-1:0] rise_o;
    logic [W-1:0] fall_o;
    logic [W-1:0] event_o;

    int tests;
    int fails;

    switch_debounce #(
        .WIDTH(W),
        .STABLE_CYCLES(SC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .sw_i(sw_i),
        .clr_i(clr_i),
        .sw_o(sw_o),
        .rise_o(rise_o),
        .fall_o(fall_o),
        .event_o(event_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled at the falling edge.
    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
        end
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        sw_i  = '0;
        clr_i = 1'b0;
        tick(2);
        rst = 1'b0;
        tick(2);
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        sw_i  = 4'hF;
        clr_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if (k == 2) rst = 1'b0;
            tick(1);
            tests++;
            if ({sw_o, rise_o, fall_o, event_o} !== 16'h0) begin
                fails++;
                $display("FAIL reset cyc%0d: got sw=%h r=%h f=%h e=%h want all 0",
                         k, sw_o, rise_o, fall_o, event_o);
            end
        end
    endtask

    task automatic test_clean_edge();
        do_reset();
        sw_i = 4'b0001;
        for (int e = 1; e <= 5; e++) begin
            tick(1);
            tests++;
            if (sw_o !== 4'b0000 || rise_o !== 4'b0000) begin
                fails++;
                $display("FAIL clean_early e%0d: got sw=%b r=%b want 0000 0000",
                         e, sw_o, rise_o);
            end
        end
        tick(1);
        tests++;
        if (sw_o !== 4'b0001 || rise_o !== 4'b0001 || event_o !== 4'b0001
            || fall_o !== 4'b0000) begin
            fails++;
            $display("FAIL clean_e6: got sw=%b r=%b f=%b e=%b want 0001 0001 0000 0001",
                     sw_o, rise_o, fall_o, event_o);
        end
        tick(1);
        tests++;
        if (rise_o !== 4'b0000 || sw_o !== 4'b0001) begin
            fails++;
            $display("FAIL clean_e7: got sw=%b r=%b want 0001 0000", sw_o, rise_o);
        end
    endtask

    task automatic test_bounce();
        logic [6:0] pat;
        pat = 7'b1110111;
        do_reset();
        for (int k = 6; k >= 0; k--) begin
            sw_i = {1'b0, pat[k], 2'b00};
            tick(1);
            tests++;
            if ((rise_o | fall_o) !== 4'b0000) begin
                fails++;
                $display("FAIL bounce_pulse k%0d: got r=%b f=%b want 0000 0000",
                         k, rise_o, fall_o);
            end
        end
        sw_i = '0;
        for (int k = 0; k < 8; k++) begin
            tick(1);
            tests++;
            if ((rise_o | fall_o) !== 4'b0000) begin
                fails++;
                $display("FAIL bounce_tail k%0d: got r=%b f=%b want 0000 0000",
                         k, rise_o, fall_o);
            end
        end
        tests++;
        if (sw_o !== 4'b0000 || event_o !== 4'b0000) begin
            fails++;
            $display("FAIL bounce_level: got sw=%b e=%b want 0000 0000",
                     sw_o, event_o);
        end
    endtask

    task automatic test_fall_multi();
        do_reset();
        sw_i = 4'hF;
        tick(7);
        tests++;
        if (sw_o !== 4'hF || event_o !== 4'hF) begin
            fails++;
            $display("FAIL fall_setup: got sw=%h e=%h want F F", sw_o, event_o);
        end
        clr_i = 1'b1;
        tick(1);
        clr_i = 1'b0;
        tests++;
        if (event_o !== 4'h0) begin
            fails++;
            $display("FAIL fall_clear: got e=%h want 0", event_o);
        end
        sw_i = 4'b0101;
        for (int e = 1; e <= 5; e++) begin
            tick(1);
            tests++;
            if (fall_o !== 4'b0000 || sw_o !== 4'hF) begin
                fails++;
                $display("FAIL fall_early e%0d: got sw=%b f=%b want 1111 0000",
                         e, sw_o, fall_o);
            end
        end
        tick(1);
        tests++;
        if (fall_o !== 4'b1010 || rise_o !== 4'b0000 || sw_o !== 4'b0101
            || event_o !== 4'b1010) begin
            fails++;
            $display("FAIL fall_e6: got sw=%b r=%b f=%b e=%b want 0101 0000 1010 1010",
                     sw_o, rise_o, fall_o, event_o);
        end
        tick(1);
        tests++;
        if (fall_o !== 4'b0000) begin
            fails++;
            $display("FAIL fall_e7: got f=%b want 0000", fall_o);
        end
    endtask

    task automatic test_clear_collision();
        clr_i = 1'b1;
        tick(1);
        clr_i = 1'b0;
        sw_i = 4'b1101;
        tick(7);
        tests++;
        if (event_o !== 4'b1000 || sw_o !== 4'b1101) begin
            fails++;
            $display("FAIL coll_setup: got sw=%b e=%b want 1101 1000", sw_o, event_o);
        end
        sw_i = 4'b1100;
        tick(5);
        clr_i = 1'b1;
        tick(1);
        clr_i = 1'b0;
        tests++;
        if (event_o !== 4'b0001 || fall_o !== 4'b0001 || sw_o !== 4'b1100) begin
            fails++;
            $display("FAIL coll_edge: got sw=%b f=%b e=%b want 1100 0001 0001",
                     sw_o, fall_o, event_o);
        end
        tick(1);
        tests++;
        if (event_o !== 4'b0001) begin
            fails++;
            $display("FAIL coll_hold: got e=%b want 0001", event_o);
        end
    endtask

    task automatic test_reset_midcount();
        do_reset();
        sw_i = 4'b0001;
        tick(4);
        rst   = 1'b1;
        clr_i = 1'b1;
        tick(1);
        rst   = 1'b0;
        clr_i = 1'b0;
        tests++;
        if (sw_o !== 4'b0000 || rise_o !== 4'b0000 || event_o !== 4'b0000) begin
            fails++;
            $display("FAIL mid_rst: got sw=%b r=%b e=%b want 0000 0000 0000",
                     sw_o, rise_o, event_o);
        end
        for (int e = 1; e <= 5; e++) begin
            tick(1);
            tests++;
            if (rise_o !== 4'b0000 || sw_o !== 4'b0000) begin
                fails++;
                $display("FAIL mid_early e%0d: got sw=%b r=%b want 0000 0000",
                         e, sw_o, rise_o);
            end
        end
        tick(1);
        tests++;
        if (rise_o !== 4'b0001 || sw_o !== 4'b0001) begin
            fails++;
            $display("FAIL mid_e6: got sw=%b r=%b want 0001 0001", sw_o, rise_o);
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst   = 1'b1;
        sw_i  = '0;
        clr_i = 1'b0;
        test_reset();
        test_clean_edge();
        test_bounce();
        test_fall_multi();
        test_clear_collision();
        test_reset_midcount();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/switch_debounce.md
# switch_debounce

Synchronises and debounces the raw board switch inputs before they reach the switch I/O read port, so the CPU never sees metastable or bouncing values. Per-bit: two-flop synchroniser, stability counter, debounced level, one-cycle rise/fall pulses, and a sticky change flag the CPU can poll and clear. Sits between the top-level `sw` pins and the switch read-data path; the top-level reset drives `rst`.

## Interface
Parameters:
- `WIDTH`, 4, number of switch bits.
- `STABLE_CYCLES`, 500000, consecutive cycles a synchronised input must differ from the debounced level before the level flips; legal range >= 1.

Ports:
- `clk`  input  1  system clock; all state updates on rising edge.
- `rst`  input  1  reset; synchronous, active-high.
- `sw_i`  input  WIDTH  raw asynchronous switch pins.
- `clr_i`  input  1  one-cycle request to clear all bits of `event_o`.
- `sw_o`  output  WIDTH  debounced switch level.
- `rise_o`  output  WIDTH  one-cycle pulse per bit on debounced 0->1.
- `fall_o`  output  WIDTH  one-cycle pulse per bit on debounced 1->0.
- `event_o`  output  WIDTH  sticky per-bit "level changed since last clear".

## Operation
- Synchroniser: `sync1 <= sw_i`, `sync2 <= sync1`. Only `sync2` is used downstream.
- Counter per bit, width max(1, clog2(STABLE_CYCLES)); unsigned, never wraps.
- Per bit, each edge:
  - `sync2 == sw_o`: counter <= 0; no pulse.
  - `sync2 != sw_o` and counter < STABLE_CYCLES-1: counter <= counter+1.
  - `sync2 != sw_o` and counter == STABLE_CYCLES-1: `sw_o <= sync2`, counter <= 0, `rise_o` (if new level 1) or `fall_o` (if 0) high for exactly the next cycle.
- Any single cycle of agreement restarts the count: bounces shorter than STABLE_CYCLES never propagate.
- `event_o[i]` sets on the edge `sw_o[i]` flips; all bits clear on an edge with `clr_i`=1. Set and clear on the same edge: set wins for that bit, other bits clear.
- Bits are fully independent; simultaneous flips on several bits each pulse and set their own flag.

## Timing
- Reset values (edge with `rst`=1): `sync1`, `sync2`, `sw_o`, counters, `rise_o`, `fall_o`, `event_o` all 0. `rst` overrides `clr_i` and all counting.
- Latency: sw_i stable from edge 1 (first sampling edge) -> `sw_o`, pulse and event flag change at edge STABLE_CYCLES+2; pulse deasserts at edge STABLE_CYCLES+3.
- Reset mid-count: counter discarded; a switch held high through reset re-debounces from scratch and produces a fresh `rise_o` STABLE_CYCLES+2 edges after `rst` deasserts.
- Outputs registered; no combinational path from `sw_i` or `clr_i` to any output.
- `clr_i` effective on the edge it is sampled; `event_o` low the following cycle.

## Test plan
- Reset: hold `rst` 2 cycles with `sw_i`=4'hF -> all outputs 0 during and 1 cycle after reset.
- Clean edge, STABLE_CYCLES=4: `sw_i` 0->4'b0001 before edge 1 -> `sw_o`=4'b0001, `rise_o`=4'b0001, `event_o`=4'b0001 after edge 6; `rise_o`=0 after edge 7.
- Bounce, STABLE_CYCLES=4: bit 2 toggles high 3 cycles, low 1, high 3, low -> `sw_o[2]` stays 0, no pulses, `event_o` 0.
- Fall + multi-bit: from `sw_o`=4'hF, drive 4'b0101 -> bits 1 and 3 `fall_o` pulse on the same cycle, `sw_o`=4'b0101, `event_o`=4'b1010.
- Clear collision: `clr_i`=1 on the same edge bit 0 flips while `event_o`=4'b1000 -> `event_o`=4'b0001 next cycle.
- Reset mid-count, STABLE_CYCLES=4: `rst` pulse after counter reaches 2 with `sw_i[0]`=1 held -> `sw_o[0]`=0 after reset, then `rise_o[0]` pulses 6 edges after `rst` deasserts.
